// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's memory-side and decode-side handshakes.
// master = the fetch unit, slave = instruction memory / decode / bench.
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  // Instruction memory request channel
  logic                  o_imem_req_valid;
  logic                  i_imem_req_ready;
  logic [ADDR_WIDTH-1:0] o_imem_req_addr;

  // Instruction memory response channel (in order, always accepted)
  logic                  i_imem_rsp_valid;
  logic [DATA_WIDTH-1:0] i_imem_rsp_data;

  // Branch/jump redirect
  logic                  i_redirect_valid;
  logic [ADDR_WIDTH-1:0] i_redirect_pc;

  // Decode channel
  logic                  o_instr_valid;
  logic                  i_instr_ready;
  logic [DATA_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0] o_instr_pc;
  logic [6:0]            o_op_code;
  logic [2:0]            o_funct3;
  logic [6:0]            o_funct7;

  modport master (
    output o_imem_req_valid, o_imem_req_addr,
    input  i_imem_req_ready,
    input  i_imem_rsp_valid, i_imem_rsp_data,
    input  i_redirect_valid, i_redirect_pc,
    output o_instr_valid, o_instr, o_instr_pc, o_op_code, o_funct3, o_funct7,
    input  i_instr_ready
  );

  modport slave (
    input  o_imem_req_valid, o_imem_req_addr,
    output i_imem_req_ready,
    output i_imem_rsp_valid, i_imem_rsp_data,
    output i_redirect_valid, i_redirect_pc,
    input  o_instr_valid, o_instr, o_instr_pc, o_op_code, o_funct3, o_funct7,
    output i_instr_ready
  );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers in-order
// responses in a small FIFO and hands {instr, pc, fields} to decode; redirects flush.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DATA_WIDTH-1:0] NOP       = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
  localparam logic [CNT_W:0]        DEPTH_OCC = (CNT_W + 1)'(BUF_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  // Architectural state
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  entry_t                fifo_q [BUF_DEPTH];

  // Cycle events
  logic [CNT_W:0]        occupancy;
  logic                  req_valid;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  rsp_drop;
  logic                  push;
  logic                  instr_valid;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  entry_t                head;
  logic [DATA_WIDTH-1:0] instr;

  // Responses reaching the unit with nothing outstanding (e.g. straddling a
  // reset) are ignored; every accepted response either refills or is dropped.
  always_comb begin
    occupancy   = {1'b0, count_q} + {1'b0, outstanding_q};
    req_valid   = !i_reset && !bus.i_redirect_valid && (occupancy < DEPTH_OCC);
    req_fire    = req_valid && bus.i_imem_req_ready;
    rsp_fire    = bus.i_imem_rsp_valid && (outstanding_q != '0);
    rsp_drop    = rsp_fire && (drop_q != '0);
    push        = rsp_fire && (drop_q == '0) && !bus.i_redirect_valid;
    instr_valid = (count_q != '0);
    pop         = instr_valid && bus.i_instr_ready && !bus.i_redirect_valid;
    redirect_pc = {bus.i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (bus.i_redirect_valid) begin
      // Everything still in flight becomes a word to discard; a response
      // arriving right now is itself discarded and no longer in flight.
      fetch_pc_d    = redirect_pc;
      rsp_pc_d      = redirect_pc;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - CNT_W'(rsp_fire);
      drop_d        = outstanding_q - CNT_W'(rsp_fire);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      drop_d        = drop_q - CNT_W'(rsp_drop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (i_reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count_q gates every read, so
  // stale contents are never visible and the array can map onto plain RAM cells.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{instr: bus.i_imem_rsp_data, pc: rsp_pc_q};
    end
  end

  always_comb begin
    head  = fifo_q[rd_ptr_q];
    instr = instr_valid ? head.instr : NOP;
  end

  assign bus.o_imem_req_valid = req_valid;
  assign bus.o_imem_req_addr  = fetch_pc_q;
  assign bus.o_instr_valid    = instr_valid;
  assign bus.o_instr          = instr;
  assign bus.o_instr_pc       = instr_valid ? head.pc : rsp_pc_q;
  assign bus.o_op_code        = instr[6:0];
  assign bus.o_funct3         = instr[14:12];
  assign bus.o_funct7         = instr[31:25];

  // Redirect targets are forced to word alignment; the low bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.i_redirect_pc[1:0];

  // Structural invariants of the credit scheme.
  a_credit_bound : assert property (@(posedge i_clk) disable iff (i_reset)
    occupancy <= DEPTH_OCC);

  a_drop_bound : assert property (@(posedge i_clk) disable iff (i_reset)
    drop_q <= outstanding_q);

  a_req_stable : assert property (@(posedge i_clk) disable iff (i_reset)
    (bus.o_imem_req_valid && !bus.i_imem_req_ready) |=>
      (i_reset || bus.i_redirect_valid ||
       (bus.o_imem_req_valid && $stable(bus.o_imem_req_addr))));

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a queue-based memory/stream model
// predicts request credit, addresses and the in-order instruction stream.
module tb_instr_fetch_unit;

  localparam int          DW       = 32;
  localparam int          AW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum int {M_RESET, M_FAST, M_DSTALL, M_MSTALL, M_RAND} mode_e;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;

  always #5 i_clk = ~i_clk;

  instr_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_fetch_unit #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  // Model: memory requests in flight (oldest first) and words buffered for decode.
  req_t        pend[$];
  ent_t        buff[$];
  logic [31:0] m_fpc;
  bit          m_known;

  mode_e       mode;
  int          cyc;
  int          lat_fix;
  bit          force_redir;
  logic [31:0] force_pc;
  int          dut_fires;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F13;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_cycle();
    bit          exp_rv;
    bit          rsp_hit;
    int          lat;
    req_t        r;
    logic [31:0] d;

    @(posedge i_clk);
    #1;
    cyc++;

    // Drive stimulus for this cycle
    i_reset = (mode == M_RESET) || (mode == M_RAND && $urandom_range(0, 199) == 0);
    if (force_redir) begin
      bus.i_redirect_valid = 1'b1;
      bus.i_redirect_pc    = force_pc;
    end else begin
      bus.i_redirect_valid = (mode == M_RAND) && ($urandom_range(0, 15) == 0);
      bus.i_redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : 32'($urandom);
    end
    force_redir = 1'b0;

    case (mode)
      M_MSTALL: bus.i_imem_req_ready = 1'b0;
      M_RAND:   bus.i_imem_req_ready = ($urandom_range(0, 3) != 0);
      default:  bus.i_imem_req_ready = 1'b1;
    endcase

    if (pend.size() > 0 && pend[0].due <= cyc &&
        (mode != M_RAND || $urandom_range(0, 3) != 0)) begin
      bus.i_imem_rsp_valid = 1'b1;
      bus.i_imem_rsp_data  = mem_word(pend[0].addr);
    end else if (pend.size() == 0 && mode == M_RAND && $urandom_range(0, 7) == 0) begin
      bus.i_imem_rsp_valid = 1'b1;             // stray response, nothing outstanding
      bus.i_imem_rsp_data  = 32'($urandom);
    end else begin
      bus.i_imem_rsp_valid = 1'b0;
      bus.i_imem_rsp_data  = 32'($urandom);
    end

    case (mode)
      M_DSTALL: bus.i_instr_ready = 1'b0;
      M_RAND:   bus.i_instr_ready = ($urandom_range(0, 2) != 0);
      default:  bus.i_instr_ready = 1'b1;
    endcase

    @(negedge i_clk);

    // Compare against the model
    exp_rv = !i_reset && !bus.i_redirect_valid && (buff.size() + pend.size() < DEPTH);
    if (bus.o_imem_req_valid && bus.i_imem_req_ready) dut_fires++;
    if (m_known) begin
      check("req_valid", 64'(bus.o_imem_req_valid), 64'(exp_rv));
      if (exp_rv) check("req_addr", 64'(bus.o_imem_req_addr), 64'(m_fpc));
      check("instr_valid", 64'(bus.o_instr_valid), 64'(buff.size() != 0));
      if (buff.size() != 0) begin
        d = buff[0].data;
        check("instr", 64'(bus.o_instr), 64'(d));
        check("instr_pc", 64'(bus.o_instr_pc), 64'(buff[0].pc));
        check("opcode", 64'(bus.o_op_code), 64'(d[6:0]));
        check("funct3", 64'(bus.o_funct3), 64'(d[14:12]));
        check("funct7", 64'(bus.o_funct7), 64'(d[31:25]));
      end else begin
        check("instr_nop", 64'(bus.o_instr), 64'(NOP));
      end
    end

    // Advance the model across the coming edge
    if (i_reset) begin
      pend.delete();
      buff.delete();
      m_fpc   = RESET_PC;
      m_known = 1'b1;
    end else begin
      rsp_hit = bus.i_imem_rsp_valid && (pend.size() > 0);
      if (bus.i_redirect_valid) begin
        if (rsp_hit) void'(pend.pop_front());
        foreach (pend[i]) pend[i].stale = 1'b1;
        buff.delete();
        m_fpc = {bus.i_redirect_pc[31:2], 2'b00};
      end else begin
        if (rsp_hit) begin
          r = pend.pop_front();
          if (bus.i_instr_ready && buff.size() > 0) void'(buff.pop_front());
          if (!r.stale) buff.push_back('{pc: r.addr, data: mem_word(r.addr)});
        end else if (bus.i_instr_ready && buff.size() > 0) begin
          void'(buff.pop_front());
        end
        if (exp_rv && bus.i_imem_req_ready) begin
          lat = (mode == M_RAND) ? $urandom_range(1, 4) : lat_fix;
          pend.push_back('{addr: m_fpc, due: cyc + lat, stale: 1'b0});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
  endtask

  task automatic run(input mode_e m, input int n);
    mode = m;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1'b1;
    force_pc    = pc;
    do_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    lat_fix  = 1;
    m_known  = 1'b0;
    m_fpc    = RESET_PC;
    force_redir = 1'b0;
    force_pc    = '0;
    dut_fires   = 0;
    bus.i_imem_req_ready = 1'b0;
    bus.i_imem_rsp_valid = 1'b0;
    bus.i_imem_rsp_data  = '0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_instr_ready    = 1'b0;

    // Reset state (held reset: no request, empty buffer, NOP at RESET_PC)
    run(M_RESET, 3);
    check("rst_req_valid", 64'(bus.o_imem_req_valid), 64'(0));
    check("rst_instr_valid", 64'(bus.o_instr_valid), 64'(0));
    check("rst_instr_pc", 64'(bus.o_instr_pc), 64'(RESET_PC));
    check("rst_req_addr", 64'(bus.o_imem_req_addr), 64'(RESET_PC));

    // Streaming fetch at full rate
    run(M_FAST, 24);

    // Decode stall from reset: exactly DEPTH requests, then drain in order
    run(M_RESET, 2);
    dut_fires = 0;
    run(M_DSTALL, 12);
    check("stall_req_count", 64'(dut_fires), 64'(DEPTH));
    check("stall_full_valid", 64'(bus.o_instr_valid), 64'(1));
    run(M_FAST, 10);

    // Redirect with two responses in flight, unaligned target
    lat_fix = 3;
    run(M_RESET, 2);
    run(M_FAST, 2);
    redirect_to(32'h0000_0103);
    do_cycle();
    check("redir_addr_align", 64'(bus.o_imem_req_addr), 64'(32'h100));
    check("redir_flushed", 64'(bus.o_instr_valid), 64'(0));
    run(M_FAST, 12);
    lat_fix = 1;

    // Redirect while the buffer is full
    run(M_DSTALL, 8);
    redirect_to(32'h0000_0200);
    do_cycle();
    check("redir_full_flush", 64'(bus.o_instr_valid), 64'(0));
    run(M_FAST, 8);

    // Memory back-pressure: address held, single handshake afterwards
    run(M_RESET, 2);
    run(M_MSTALL, 3);
    check("mstall_addr", 64'(bus.o_imem_req_addr), 64'(RESET_PC));
    mode = M_FAST;
    dut_fires = 0;
    do_cycle();
    check("mstall_one_fire", 64'(dut_fires), 64'(1));
    run(M_MSTALL, 1);
    check("mstall_advance", 64'(bus.o_imem_req_addr), 64'(RESET_PC + 32'd4));

    // Reset mid-flight with a stalled decode and slow memory
    lat_fix = 3;
    run(M_DSTALL, 3);
    run(M_RESET, 1);
    check("midrst_req_valid", 64'(bus.o_imem_req_valid), 64'(0));
    run(M_RESET, 1);
    check("midrst_empty", 64'(bus.o_instr_valid), 64'(0));
    lat_fix = 1;
    run(M_RAND, 20);

    // PC wrap past the top of the address space
    run(M_FAST, 2);
    redirect_to(32'hFFFF_FFF6);
    run(M_FAST, 16);

    // Long randomized run
    run(M_RAND, 4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_instr_fetch_unit
